// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default widths for the APB command master
package apb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - command queue, wrap-bit pointers, registered storage
module apb_cmd_fifo
   import apb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = $bits(apb_cmd_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Same index with opposite wrap bits means the writer has lapped the reader.
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty    = (wr_ptr == rd_ptr);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - queued command port driving back-to-back APB transfers
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata
);

   localparam int CMD_W = 1 + ADDR_W + DATA_W;

   logic             full;
   logic             empty;
   logic             pop;
   logic [CMD_W-1:0] head;

   apb_state_e        state, state_n;
   logic              psel_n, penable_n, pwrite_n;
   logic [ADDR_W-1:0] paddr_n;
   logic [DATA_W-1:0] pwdata_n;
   logic              rsp_valid_n, rsp_write_n;
   logic [DATA_W-1:0] rsp_rdata_n;

   assign cmd_ready = !full;
   assign busy      = !empty || (state != IDLE);

   apb_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmd_valid && !full),
      .push_data ({cmd_write, cmd_addr, cmd_wdata}),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      state_n     = state;
      psel_n      = psel;
      penable_n   = penable;
      paddr_n     = paddr;
      pwrite_n    = pwrite;
      pwdata_n    = pwdata;
      rsp_valid_n = 1'b0;
      rsp_write_n = rsp_write;
      rsp_rdata_n = rsp_rdata;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               pwrite_n  = head[CMD_W-1];
               paddr_n   = head[DATA_W +: ADDR_W];
               pwdata_n  = head[DATA_W-1:0];
               psel_n    = 1'b1;
               penable_n = 1'b0;
               state_n   = SETUP;
            end
         end
         SETUP: begin
            penable_n = 1'b1;
            state_n   = ACCESS;
         end
         ACCESS: begin
            rsp_valid_n = 1'b1;
            rsp_write_n = pwrite;
            rsp_rdata_n = pwrite ? '0 : prdata;
            penable_n   = 1'b0;
            // Chain straight into the next SETUP so psel never drops between queued transfers.
            if (!empty) begin
               pop      = 1'b1;
               pwrite_n = head[CMD_W-1];
               paddr_n  = head[DATA_W +: ADDR_W];
               pwdata_n = head[DATA_W-1:0];
               psel_n   = 1'b1;
               state_n  = SETUP;
            end else begin
               psel_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            psel_n    = 1'b0;
            penable_n = 1'b0;
            state_n   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_n;
         psel      <= psel_n;
         penable   <= penable_n;
         paddr     <= paddr_n;
         pwrite    <= pwrite_n;
         pwdata    <= pwdata_n;
         rsp_valid <= rsp_valid_n;
         rsp_write <= rsp_write_n;
         rsp_rdata <= rsp_rdata_n;
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master with a zero-wait responder
module tb_apb_cmd_master;
   import apb_pkg::*;

   typedef struct packed {
      logic        write;
      logic [31:0] rdata;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_write;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic [7:0]  paddr;
   logic        pwrite, psel, penable;
   logic [31:0] pwdata, prdata;

   int errors = 0;
   int checks = 0;
   int stalls = 0;
   int rsp_seen = 0;
   logic        last_write;
   logic [31:0] last_rdata;

   logic [31:0] slave_mem [256];
   logic [31:0] model_mem [256];
   rsp_t        exp_rsp_q [$];
   apb_cmd_t    exp_cmd_q [$];

   apb_cmd_master #(.ADDR_W(8), .DATA_W(32), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .busy(busy), .paddr(paddr), .pwrite(pwrite), .psel(psel),
      .penable(penable), .pwdata(pwdata), .prdata(prdata)
   );

   always #5 clk = ~clk;

   // Zero-wait responder: combinational read, write committed at the end of ACCESS.
   assign prdata = slave_mem[paddr];
   always @(posedge clk) begin
      if (psel && penable && pwrite) slave_mem[paddr] <= pwdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: transfers execute in acceptance order against a flat memory.
   task automatic model_accept(input logic w, input logic [7:0] a, input logic [31:0] d);
      apb_cmd_t c;
      rsp_t     r;
      c.write = w; c.addr = a; c.wdata = d;
      exp_cmd_q.push_back(c);
      r.write = w;
      r.rdata = w ? 32'h0 : model_mem[a];
      if (w) model_mem[a] = d;
      exp_rsp_q.push_back(r);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high.
   task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
         stalls++;
      end
      if (!cmd_ready) begin
         chk("send_timeout", 32'(cmd_ready), 32'h1);
         cmd_valid = 1'b0;
         return;
      end
      model_accept(w, a, d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      cmd_valid = 1'b0;
      while ((exp_rsp_q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(exp_rsp_q.size()), 32'h0);
      chk("drain_busy", 32'(busy), 32'h0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (penable) chk("penable_without_psel", 32'(psel), 32'h1);
         if (rsp_valid) begin
            rsp_seen++;
            last_write = rsp_write;
            last_rdata = rsp_rdata;
            if (exp_rsp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
               rsp_t r;
               r = exp_rsp_q.pop_front();
               chk("rsp_write", 32'(rsp_write), 32'(r.write));
               chk("rsp_rdata", rsp_rdata, r.rdata);
            end
         end
         if (psel && !penable) begin
            if (exp_cmd_q.size() == 0) begin
               chk("setup_unexpected", 32'(psel), 32'h0);
            end else begin
               apb_cmd_t c;
               c = exp_cmd_q.pop_front();
               chk("setup_paddr", 32'(paddr), 32'(c.addr));
               chk("setup_pwrite", 32'(pwrite), 32'(c.write));
               if (c.write) chk("setup_pwdata", pwdata, c.wdata);
            end
         end
      end
   end

   initial begin
      logic [4:0] ps_v, rv_v;
      int n;
      int base;
      for (int i = 0; i < 256; i++) begin
         slave_mem[i] = 32'h0;
         model_mem[i] = 32'h0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_psel", 32'(psel), 32'h0);
      chk("rst_penable", 32'(penable), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_paddr", 32'(paddr), 32'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      @(negedge clk);

      // Single write latency
      send(1'b1, 8'h32, 32'h61);
      cmd_valid = 1'b0;
      chk("lat_psel_n0", 32'(psel), 32'h0);
      chk("lat_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("lat_psel_n1", 32'(psel), 32'h1);
      chk("lat_penable_n1", 32'(penable), 32'h0);
      chk("lat_paddr", 32'(paddr), 32'h32);
      chk("lat_pwrite", 32'(pwrite), 32'h1);
      chk("lat_pwdata", pwdata, 32'h61);
      @(negedge clk);
      chk("lat_penable_n2", 32'(penable), 32'h1);
      @(negedge clk);
      chk("lat_rsp_valid_n3", 32'(rsp_valid), 32'h1);
      chk("lat_rsp_write", 32'(rsp_write), 32'h1);
      chk("lat_rsp_rdata", rsp_rdata, 32'h0);
      chk("lat_psel_n3", 32'(psel), 32'h0);
      @(negedge clk);
      chk("lat_rsp_pulse_end", 32'(rsp_valid), 32'h0);
      chk("lat_busy_end", 32'(busy), 32'h0);

      // Write then read back
      send(1'b1, 8'h10, 32'h99);
      send(1'b0, 8'h10, $urandom);
      drain();
      chk("rd_back_data", last_rdata, 32'h99);
      chk("rd_back_write", 32'(last_write), 32'h0);

      // Back-to-back: no IDLE gap, responses two cycles apart
      send(1'b1, 8'h00, 32'hffff_ffff);
      send(1'b0, 8'h00, $urandom);
      cmd_valid = 1'b0;
      ps_v = '0; rv_v = '0;
      for (int i = 0; i < 5; i++) begin
         ps_v = {ps_v[3:0], psel};
         rv_v = {rv_v[3:0], rsp_valid};
         if (i < 4) @(negedge clk);
      end
      chk("b2b_psel_pattern", 32'(ps_v), 32'h1e);
      chk("b2b_rsp_pattern", 32'(rv_v), 32'h05);
      drain();
      chk("b2b_rdata", last_rdata, 32'hffff_ffff);

      // Full FIFO with cmd_valid held across pointer wrap
      stalls = 0;
      base = rsp_seen;
      for (int i = 0; i < 6; i++) send(1'($urandom), 8'($urandom_range(0, 7)), $urandom);
      drain();
      chk("full_backpressure_seen", 32'(stalls > 0), 32'h1);
      chk("full_rsp_count", 32'(rsp_seen - base), 32'h6);

      // Push lands on the edge ACCESS returns to IDLE
      send(1'b1, 8'h21, 32'h5a5a);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      send(1'b0, 8'h21, $urandom);
      cmd_valid = 1'b0;
      chk("corner_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("corner_idle_psel", 32'(psel), 32'h0);
      chk("corner_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("corner_setup_psel", 32'(psel), 32'h1);
      chk("corner_setup_penable", 32'(penable), 32'h0);
      drain();
      chk("corner_rdata", last_rdata, 32'h5a5a);

      // Random traffic with random gaps
      base = rsp_seen;
      for (int i = 0; i < 40; i++) begin
         send(1'($urandom), 8'($urandom_range(0, 7)), $urandom);
         cmd_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      chk("rand_rsp_count", 32'(rsp_seen - base), 32'd40);

      // Reset asserted during ACCESS
      send(1'b0, 8'h05, $urandom);
      cmd_valid = 1'b0;
      n = 0;
      while (!penable && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_access", 32'(penable), 32'h1);
      rst = 1'b1;
      #1;
      chk("arst_psel", 32'(psel), 32'h0);
      chk("arst_penable", 32'(penable), 32'h0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("arst_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("arst_busy", 32'(busy), 32'h0);
      exp_rsp_q.delete();
      exp_cmd_q.delete();
      @(negedge clk);
      rst = 1'b0;
      send(1'b1, 8'h44, 32'h1234);
      send(1'b0, 8'h44, $urandom);
      drain();
      chk("post_rst_rdata", last_rdata, 32'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
